// File: rtl/sum_accumulator_pkg.sv
// Shared definitions for the sum accumulator family: operand selector
// encoding and overflow handling modes.
package sum_accumulator_pkg;

  typedef enum logic [1:0] {
    SELECT_DATA_2   = 2'b00,
    SELECT_DATA_SUM = 2'b01,
    SELECT_DATA_1   = 2'b10,
    SELECT_ZERO     = 2'b11
  } selector_e;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/acc_add_sat.sv
// Widened accumulator adder: adds an unsigned addend to the accumulator,
// reports the carry out and applies wrap or saturate handling.
module acc_add_sat
  import sum_accumulator_pkg::*;
#(
  parameter int NB_DATA_OUT = 6,
  parameter int NB_ADD      = 4
) (
  input  logic [NB_DATA_OUT-1:0] i_acc,
  input  logic [NB_ADD-1:0]      i_addend,
  input  logic                   i_mode,
  output logic [NB_DATA_OUT-1:0] o_sum,
  output logic                   o_carry
);

  logic [NB_DATA_OUT:0] w_addendExt;
  logic [NB_DATA_OUT:0] w_nextSum;

  assign w_addendExt = {{(NB_DATA_OUT + 1 - NB_ADD){1'b0}}, i_addend};
  assign w_nextSum   = {1'b0, i_acc} + w_addendExt;
  assign o_carry     = w_nextSum[NB_DATA_OUT];

  // A saturated accumulator stays all-ones since any nonzero add carries again.
  always_comb begin
    o_sum = w_nextSum[NB_DATA_OUT-1:0];
    if (o_carry && (i_mode == MODE_SAT)) begin
      o_sum = '1;
    end
  end

endmodule

// File: rtl/windowed_sum_accumulator.sv
// Windowed sum accumulator: selects data1, data2 or their sum per valid
// sample, accumulates over a programmable window and emits the window total.
module windowed_sum_accumulator
  import sum_accumulator_pkg::*;
#(
  parameter int NB_DATA_IN  = 3,
  parameter int NB_SEL      = 2,
  parameter int NB_DATA_OUT = 6,
  parameter int NB_COUNT    = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid,
  input  logic [NB_DATA_IN-1:0]  i_data1,
  input  logic [NB_DATA_IN-1:0]  i_data2,
  input  logic [NB_SEL-1:0]      i_sel,
  input  logic                   i_sat_en,
  input  logic [NB_COUNT-1:0]    i_win_len,
  input  logic                   i_clear,
  output logic [NB_DATA_OUT-1:0] o_data,
  output logic [NB_DATA_OUT-1:0] o_result,
  output logic                   o_result_valid,
  output logic                   o_overflow,
  output logic                   o_acc_overflow
);

  logic [NB_DATA_OUT-1:0] r_acc;
  logic [NB_COUNT-1:0]    r_count;
  logic                   r_sticky;
  logic [NB_DATA_OUT-1:0] r_result;
  logic                   r_resultValid;
  logic                   r_overflow;

  logic [NB_DATA_IN:0]    w_data1Ext;
  logic [NB_DATA_IN:0]    w_data2Ext;
  logic [NB_DATA_IN:0]    w_selected;
  logic [NB_DATA_OUT-1:0] w_nextAcc;
  logic                   w_carry;
  logic [NB_COUNT:0]      w_countNext;
  logic                   w_accept;
  logic                   w_close;

  assign w_data1Ext = {1'b0, i_data1};
  assign w_data2Ext = {1'b0, i_data2};

  always_comb begin
    w_selected = '0;
    case (selector_e'(i_sel[1:0]))
      SELECT_DATA_1:   w_selected = w_data1Ext;
      SELECT_DATA_2:   w_selected = w_data2Ext;
      SELECT_DATA_SUM: w_selected = w_data1Ext + w_data2Ext;
      SELECT_ZERO:     w_selected = '0;
      default:         w_selected = '0;
    endcase
  end

  acc_add_sat #(
    .NB_DATA_OUT(NB_DATA_OUT),
    .NB_ADD     (NB_DATA_IN + 1)
  ) u_acc_add_sat (
    .i_acc   (r_acc),
    .i_addend(w_selected),
    .i_mode  (i_sat_en),
    .o_sum   (w_nextAcc),
    .o_carry (w_carry)
  );

  // Window length is compared live, so shortening it mid-window closes on the next sample.
  assign w_countNext = {1'b0, r_count} + {{NB_COUNT{1'b0}}, 1'b1};
  assign w_accept    = i_valid && !i_clear;
  assign w_close     = w_accept && (i_win_len != '0) && (w_countNext >= {1'b0, i_win_len});

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc         <= '0;
      r_count       <= '0;
      r_sticky      <= 1'b0;
      r_result      <= '0;
      r_resultValid <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_resultValid <= 1'b0;
      if (i_clear) begin
        r_acc    <= '0;
        r_count  <= '0;
        r_sticky <= 1'b0;
      end else if (w_close) begin
        r_result      <= w_nextAcc;
        r_overflow    <= r_sticky | w_carry;
        r_resultValid <= 1'b1;
        r_acc         <= '0;
        r_count       <= '0;
        r_sticky      <= 1'b0;
      end else if (w_accept) begin
        r_acc    <= w_nextAcc;
        r_sticky <= r_sticky | w_carry;
        // Free-running windows hold the count at its maximum instead of wrapping.
        if (!(&r_count)) begin
          r_count <= w_countNext[NB_COUNT-1:0];
        end
      end
    end
  end

  assign o_data         = r_acc;
  assign o_result       = r_result;
  assign o_result_valid = r_resultValid;
  assign o_overflow     = r_overflow;
  assign o_acc_overflow = r_sticky;

endmodule

// File: tb/tb_windowed_sum_accumulator.sv
// Self-checking bench for windowed_sum_accumulator: directed scenarios plus
// randomized traffic against an arithmetic reference model.
module tb_windowed_sum_accumulator;

  localparam int NB_DATA_IN  = 3;
  localparam int NB_SEL      = 2;
  localparam int NB_DATA_OUT = 6;
  localparam int NB_COUNT    = 4;
  localparam int ACC_MAX     = (1 << NB_DATA_OUT) - 1;
  localparam int COUNT_MAX   = (1 << NB_COUNT) - 1;

  logic                   clk;
  logic                   rstN;
  logic                   valid;
  logic [NB_DATA_IN-1:0]  data1;
  logic [NB_DATA_IN-1:0]  data2;
  logic [NB_SEL-1:0]      sel;
  logic                   satEn;
  logic [NB_COUNT-1:0]    winLen;
  logic                   clear;
  logic [NB_DATA_OUT-1:0] outData;
  logic [NB_DATA_OUT-1:0] outResult;
  logic                   outResultValid;
  logic                   outOverflow;
  logic                   outAccOverflow;

  int checkCount = 0;
  int failCount  = 0;

  int mAcc, mCount, mSticky, mResult, mOverflow, mResultValid;

  windowed_sum_accumulator #(
    .NB_DATA_IN (NB_DATA_IN),
    .NB_SEL     (NB_SEL),
    .NB_DATA_OUT(NB_DATA_OUT),
    .NB_COUNT   (NB_COUNT)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rstN),
    .i_valid       (valid),
    .i_data1       (data1),
    .i_data2       (data2),
    .i_sel         (sel),
    .i_sat_en      (satEn),
    .i_win_len     (winLen),
    .i_clear       (clear),
    .o_data        (outData),
    .o_result      (outResult),
    .o_result_valid(outResultValid),
    .o_overflow    (outOverflow),
    .o_acc_overflow(outAccOverflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".data"},       int'(outData),        mAcc);
    checkOutput({tag, ".result"},     int'(outResult),      mResult);
    checkOutput({tag, ".resultValid"}, int'(outResultValid), mResultValid);
    checkOutput({tag, ".overflow"},   int'(outOverflow),    mOverflow);
    checkOutput({tag, ".accOverflow"}, int'(outAccOverflow), mSticky);
  endtask

  task automatic modelReset();
    mAcc = 0; mCount = 0; mSticky = 0;
    mResult = 0; mOverflow = 0; mResultValid = 0;
  endtask

  // Reference behaviour for one clock edge, from the sample rules in plain arithmetic.
  task automatic modelStep();
    int addend;
    int total;
    int carry;
    int newAcc;
    mResultValid = 0;
    if (clear) begin
      mAcc = 0; mCount = 0; mSticky = 0;
    end else if (valid) begin
      case (int'(sel))
        2: addend = int'(data1);
        0: addend = int'(data2);
        1: addend = int'(data1) + int'(data2);
        default: addend = 0;
      endcase
      total  = mAcc + addend;
      carry  = (total > ACC_MAX) ? 1 : 0;
      newAcc = carry ? (satEn ? ACC_MAX : total - (ACC_MAX + 1)) : total;
      if (winLen != 0 && mCount + 1 >= int'(winLen)) begin
        mResult = newAcc; mOverflow = mSticky | carry; mResultValid = 1;
        mAcc = 0; mCount = 0; mSticky = 0;
      end else begin
        mAcc = newAcc;
        mSticky = mSticky | carry;
        if (mCount < COUNT_MAX) mCount = mCount + 1;
      end
    end
  endtask

  task automatic applyStimulus(input logic v, input int d1, input int d2, input int s,
                               input logic sat, input int win, input logic clr, input string tag);
    valid  = v;
    data1  = NB_DATA_IN'(d1);
    data2  = NB_DATA_IN'(d2);
    sel    = NB_SEL'(s);
    satEn  = sat;
    winLen = NB_COUNT'(win);
    clear  = clr;
    @(posedge clk);
    modelStep();
    #1;
    checkAll(tag);
  endtask

  task automatic idleClear();
    applyStimulus(1'b0, 0, 0, 0, 1'b0, 0, 1'b1, "clr");
  endtask

  initial begin
    rstN = 1'b0; valid = 1'b0; data1 = '0; data2 = '0; sel = '0;
    satEn = 1'b0; winLen = '0; clear = 1'b0;
    modelReset();
    #12;
    checkAll("reset");
    rstN = 1'b1;
    #5;

    // Window of 4 with sum selector
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 3, 2, 1, 1'b0, 4, 1'b0, "win4");
    checkOutput("win4.total", int'(outResult), 20);
    checkOutput("win4.strobe", int'(outResultValid), 1);
    checkOutput("win4.accZero", int'(outData), 0);
    applyStimulus(1'b0, 0, 0, 1, 1'b0, 4, 1'b0, "win4idle");
    checkOutput("win4.strobeOneCycle", int'(outResultValid), 0);

    // Wrap, free-running
    idleClear();
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 7, 7, 1, 1'b0, 0, 1'b0, "wrap");
    checkOutput("wrap.value", int'(outData), 6);
    checkOutput("wrap.sticky", int'(outAccOverflow), 1);
    applyStimulus(1'b1, 0, 0, 3, 1'b0, 0, 1'b0, "wrapHold");
    checkOutput("wrap.stickyHeld", int'(outAccOverflow), 1);

    // Saturate, free-running
    idleClear();
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 7, 7, 1, 1'b1, 0, 1'b0, "sat");
    checkOutput("sat.value", int'(outData), 63);
    checkOutput("sat.sticky", int'(outAccOverflow), 1);

    // Clear beats valid
    idleClear();
    applyStimulus(1'b1, 4, 0, 2, 1'b0, 3, 1'b0, "clrA");
    applyStimulus(1'b1, 4, 0, 2, 1'b0, 3, 1'b0, "clrB");
    applyStimulus(1'b1, 4, 0, 2, 1'b0, 3, 1'b1, "clrC");
    checkOutput("clr.acc", int'(outData), 0);
    checkOutput("clr.noStrobe", int'(outResultValid), 0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4, 0, 2, 1'b0, 3, 1'b0, "clrD");
    checkOutput("clr.total", int'(outResult), 12);

    // Valid gaps
    applyStimulus(1'b1, 0, 1, 0, 1'b0, 3, 1'b0, "gap1");
    applyStimulus(1'b0, 0, 1, 0, 1'b0, 3, 1'b0, "gap2");
    applyStimulus(1'b0, 0, 1, 0, 1'b0, 3, 1'b0, "gap3");
    applyStimulus(1'b1, 0, 1, 0, 1'b0, 3, 1'b0, "gap4");
    checkOutput("gap.noEarlyStrobe", int'(outResultValid), 0);
    applyStimulus(1'b1, 0, 1, 0, 1'b0, 3, 1'b0, "gap5");
    checkOutput("gap.total", int'(outResult), 3);
    checkOutput("gap.strobe", int'(outResultValid), 1);

    // Zero selector still counts samples
    applyStimulus(1'b1, 5, 5, 3, 1'b0, 2, 1'b0, "zeroA");
    applyStimulus(1'b1, 5, 5, 3, 1'b0, 2, 1'b0, "zeroB");
    checkOutput("zero.total", int'(outResult), 0);
    checkOutput("zero.strobe", int'(outResultValid), 1);

    // Shrinking the window mid-way closes on the next sample
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1, 0, 2, 1'b0, 8, 1'b0, "shrink");
    applyStimulus(1'b1, 1, 0, 2, 1'b0, 2, 1'b0, "shrinkClose");
    checkOutput("shrink.total", int'(outResult), 4);

    // Asynchronous reset mid-window
    applyStimulus(1'b1, 6, 0, 2, 1'b0, 4, 1'b0, "midA");
    applyStimulus(1'b1, 6, 0, 2, 1'b0, 4, 1'b0, "midB");
    checkOutput("mid.acc", int'(outData), 12);
    #3;
    rstN = 1'b0;
    #1;
    modelReset();
    checkAll("asyncReset");
    #2;
    rstN = 1'b1;

    // Randomized traffic
    winLen = NB_COUNT'($urandom_range(1, 6));
    for (int i = 0; i < 400; i++) begin
      int w;
      w = int'(winLen);
      if ($urandom_range(0, 9) == 0) w = $urandom_range(0, COUNT_MAX);
      applyStimulus(($urandom_range(0, 3) != 0), $urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, 3), logic'($urandom_range(0, 1)), w,
                    ($urandom_range(0, 19) == 0), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/windowed_sum_accumulator.md
Name: windowed_sum_accumulator

Overview:
Parametrised successor to the single-channel sum accumulator. It selects data1, data2 or data1+data2 per sample and accumulates over a programmable window of N valid samples. At the end of each window it emits the window total with a one-cycle result strobe and a per-window overflow flag, then restarts from zero. It adds an input valid qualifier, a wrap/saturate mode and a synchronous clear, and sits between the sample source and the downstream statistics logic.

Parameters:
NB_DATA_IN, 3, width of each unsigned input operand
NB_SEL, 2, selector width
NB_DATA_OUT, 6, accumulator/result width; must be >= NB_DATA_IN+1
NB_COUNT, 4, window-length field width; windows of 1..2^NB_COUNT-1 samples

Ports:
i_clk  in  1  clock, all state updates on rising edge
i_rst_n  in  1  asynchronous active-low reset
i_valid  in  1  sample qualifier; sample accepted when high (no backpressure)
i_data1  in  NB_DATA_IN  operand 1, unsigned
i_data2  in  NB_DATA_IN  operand 2, unsigned
i_sel  in  NB_SEL  10=data1, 00=data2, 01=data1+data2, 11=zero (sample counted, adds 0)
i_sat_en  in  1  1=saturate at all-ones, 0=wrap modulo 2^NB_DATA_OUT
i_win_len  in  NB_COUNT  samples per window; 0=free-running, never closes
i_clear  in  1  synchronous clear of running state
o_data  out  NB_DATA_OUT  running accumulator value (registered)
o_result  out  NB_DATA_OUT  total of last completed window, held until next window closes
o_result_valid  out  1  one-cycle pulse when o_result updates
o_overflow  out  1  overflow flag of last completed window, updated with o_result
o_acc_overflow  out  1  sticky overflow within current window

Behaviour:
- Reset (async, i_rst_n=0): accumulator, sample counter, all outputs = 0, immediately.
- Operand path: zero-extend operands to NB_DATA_IN+1 bits; sum never loses a bit; zero-extend selection to NB_DATA_OUT+1 bits.
- next = {0,acc} + sel_ext; carry = next[NB_DATA_OUT].
- carry=1: wrap mode keeps low NB_DATA_OUT bits; sat mode forces all-ones. Either mode sets window-overflow flag.
- Saturated accumulator stays all-ones on further adds; carry still asserts overflow.
- Accepted sample (i_valid=1, i_clear=0): acc <= next (wrap/sat applied), count <= count+1.
- Window close: accepted sample with i_win_len!=0 and count+1 >= i_win_len.
  - Same edge: o_result <= next value (wrap/sat applied); o_overflow <= sticky | carry; o_result_valid <= 1.
  - acc, count, sticky cleared, so o_data shows 0 on the following cycle.
- Latency: o_result_valid high the cycle after the closing sample's edge, exactly one cycle.
- i_valid=0: state held, o_result_valid=0.
- i_clear=1: acc, count, o_acc_overflow <= 0. Clear beats a simultaneous valid; that sample is dropped and no window closes. o_result/o_overflow are not affected.
- i_win_len changed mid-window: compared live. If the count already meets or exceeds the new length, the next accepted sample closes the window.
- Free-running (i_win_len=0): never closes; o_acc_overflow sticky until i_clear.
- Counter width NB_COUNT; it never wraps because close occurs at or before 2^NB_COUNT-1.
- i_sel/i_sat_en sampled per accepted sample; changes take effect immediately.

Decomposition:
- Package sum_accumulator_pkg: selector_e enum (SELECT_DATA_1=2'b10, SELECT_DATA_2=2'b00, SELECT_DATA_SUM=2'b01, SELECT_ZERO=2'b11), mode constants MODE_WRAP=0/MODE_SAT=1. Shared with the existing accumulator.
- One sub-module, acc_add_sat: combinational widened add plus wrap/saturate select and carry output, parametrised by NB_DATA_OUT.
- Top holds the counter, sticky flag, result registers and close logic.

Test Plan:
- Reset mid-window (acc=12, count=2), pull i_rst_n low between clock edges -> all outputs 0 before the next edge.
- win_len=4, sel=01, data1=3, data2=2, valid 4 cycles -> o_data 5,10,15 then 0; o_result=20 with a 1-cycle o_result_valid; o_overflow=0.
- Wrap, win_len=0, sel=01, data 7+7 five times -> o_data 14,28,42,56,6; o_acc_overflow=1 from the fifth sample and stays 1.
- Saturate, same stimulus -> o_data 14,28,42,56,63,63; o_acc_overflow=1.
- win_len=3, sel=10 data1=4, sample, sample, then i_clear with i_valid on the third -> acc=0, no o_result_valid; three further samples -> o_result=12.
- i_valid gaps (1,0,0,1,1) with win_len=3, sel=00 data2=1 -> o_result=3, strobe only after the third accepted sample.
- sel=11 with valid samples, win_len=2 -> o_result=0, o_result_valid pulses.
